cmd_dispatcher: RTL

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

---
 rtl/cmd_dispatcher.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cmd_dispatcher.sv
// Queues parsed commands and serves them in order to SPI/I2C/UART/PWM; first periph_req 2 cycles after cmd_valid.
// Full queue drops the command (drop_pulse); rsp held until rsp_ready; CMD_TIMEOUT_EN adds an issue/wait watchdog.
module cmd_dispatcher #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_opcode,
  input  logic [2:0] cmd_periph,
  input  logic [7:0] cmd_para,
  output logic [3:0] periph_req,
  output logic [4:0] periph_op,
  output logic [7:0] periph_para,
  input  logic [3:0] periph_ack,
  input  logic [3:0] periph_done,
  input  logic [3:0] periph_err,
  output logic       rsp_valid,
  output logic [7:0] rsp_code,
  output logic [2:0] rsp_periph,
  input  logic       rsp_ready,
  output logic       busy,
  output logic       drop_pulse
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]    state;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic [2:0]    cur_id;
  logic          ack_hit;
  logic          done_hit;
  logic          err_hit;
  logic          tmo_hit;
  logic          unused_opcode_bits;

  // Push decision uses occupancy before any same-cycle pop, so a full queue drops even while IDLE pops.
  assign fifo_full = (count == DEPTH_C);
  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state == ST_IDLE) && (count != '0);
  assign head      = fifo_mem[rd_ptr];
  assign ack_hit   = periph_ack[cur_id[1:0]];
  assign done_hit  = periph_done[cur_id[1:0]];
  assign err_hit   = periph_err[cur_id[1:0]];
  assign busy      = (state != ST_IDLE);
  assign unused_opcode_bits = ^cmd_opcode[7:5];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_periph, cmd_opcode[4:0], cmd_para};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      tmo_cnt <= '0;
    else if (state == ST_ISSUE || state == ST_WAIT) tmo_cnt <= tmo_cnt + TW'(1);
    else                                             tmo_cnt <= '0;
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cur_id      <= '0;
      periph_req  <= '0;
      periph_op   <= '0;
      periph_para <= '0;
      rsp_valid   <= 1'b0;
      rsp_code    <= '0;
      rsp_periph  <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      drop_pulse <= cmd_valid && fifo_full;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_id <= head[15:13];
            if (!head[15]) begin
              state       <= ST_ISSUE;
              periph_req  <= 4'b0001 << head[14:13];
              periph_op   <= head[12:8];
              periph_para <= head[7:0];
            end else begin
              state      <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_code   <= 8'h02;
              rsp_periph <= head[15:13];
            end
          end
        end
        // Ack or done in the watchdog's last cycle takes priority over the timeout.
        ST_ISSUE: begin
          if (ack_hit) begin
            state      <= ST_WAIT;
            periph_req <= '0;
          end else if (tmo_hit) begin
            state      <= ST_RESP;
            periph_req <= '0;
            rsp_valid  <= 1'b1;
            rsp_code   <= 8'h03;
            rsp_periph <= cur_id;
          end
        end
        ST_WAIT: begin
          if (done_hit) begin
            state      <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_code   <= {7'b0, err_hit};
            rsp_periph <= cur_id;
          end else if (tmo_hit) begin
            state      <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_code   <= 8'h03;
            rsp_periph <= cur_id;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
